// File: rtl/point_addition_pkg.sv
// Shared state encoding and curve constants for the point_addition block.
// Doubling support is compiled in only when POINT_DOUBLE_EN is defined.
package point_addition_pkg;

  localparam int N = 256;
  localparam int A = 0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    LAMBDA,
    INV,
    X3,
    Y3,
    DONE
  } state_t;

  // Outcome of the special-case decision taken in CHECK.
  typedef enum logic [2:0] {
    CASE_ADD,
    CASE_DBL,
    CASE_INF,
    CASE_P,
    CASE_Q
  } case_t;

endpackage

// File: rtl/mod_mult.sv
// Bit-serial interleaved modular multiplier: MSB-first double-and-add, one
// operand bit per cycle, so a product takes n+2 cycles from start to done.
module mod_mult
  import point_addition_pkg::*;
#(
  parameter int n = N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [n-1:0] p,
  input  logic         start,
  output logic [n-1:0] product,
  output logic         done
);

  localparam int CW = $clog2(n + 1);

  logic [n-1:0]  a_r;
  logic [n-1:0]  b_r;
  logic [n-1:0]  p_r;
  logic [n-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          busy;
  logic [n:0]    dbl_raw;
  logic [n:0]    dbl_red;
  logic [n:0]    sum_raw;
  logic [n:0]    sum_red;

  // acc < p keeps 2*acc and 2*acc + a below 2p, so one correction each suffices.
  always_comb begin
    dbl_raw = {acc, 1'b0};
    dbl_red = (dbl_raw >= {1'b0, p_r}) ? dbl_raw - {1'b0, p_r} : dbl_raw;
    sum_raw = b_r[n-1] ? dbl_red + {1'b0, a_r} : dbl_red;
    sum_red = (sum_raw >= {1'b0, p_r}) ? sum_raw - {1'b0, p_r} : sum_raw;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r  <= '0;
      b_r  <= '0;
      p_r  <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_r  <= a;
        b_r  <= b;
        p_r  <= p;
        acc  <= '0;
        cnt  <= CW'(n);
        busy <= 1'b1;
      end else if (busy) begin
        acc <= sum_red[n-1:0];
        b_r <= {b_r[n-2:0], 1'b0};
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/point_addition.sv
// One-shot affine point addition on y^2 = x^3 + a*x + b mod p (a = 0).
// Define POINT_DOUBLE_EN to compile in the P == Q doubling path.
module point_addition
  import point_addition_pkg::*;
#(
  parameter int n = N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] p,
  input  logic [n-1:0] x1,
  input  logic [n-1:0] y1,
  input  logic [n-1:0] x2,
  input  logic [n-1:0] y2,
  output logic [n-1:0] x3,
  output logic [n-1:0] y3,
  output logic         result,
  output logic         infinity
);

  localparam logic [n-1:0] ONE     = n'(1);
  localparam logic [n-1:0] CURVE_A = n'(A);

  state_t       st, st_nxt;
  logic         ph, ph_nxt;
  case_t        chk;
  logic [n-1:0] pr, xa, ya, xb, yb;
  logic [n-1:0] num, lam, xr, sy;
  logic [n-1:0] u, v, s, t;
  logic         dbl;
  logic         p_o, q_o, u_one, v_one;
  logic [n-1:0] mul_a, mul_b, mul_prod;
  logic         mul_start, mul_done;

  function automatic logic [n-1:0] madd(input logic [n-1:0] a, input logic [n-1:0] b,
                                        input logic [n-1:0] m);
    logic [n:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, m}) sum = sum - {1'b0, m};
    return sum[n-1:0];
  endfunction

  function automatic logic [n-1:0] msub(input logic [n-1:0] a, input logic [n-1:0] b,
                                        input logic [n-1:0] m);
    logic [n:0] dif;
    dif = {1'b0, a} - {1'b0, b};
    if (dif[n]) dif = dif + {1'b0, m};
    return dif[n-1:0];
  endfunction

  // Division by two mod an odd m: add m first when the value is odd.
  function automatic logic [n-1:0] mhalf(input logic [n-1:0] a, input logic [n-1:0] m);
    logic [n:0] sum;
    sum = a[0] ? {1'b0, a} + {1'b0, m} : {1'b0, a};
    return sum[n:1];
  endfunction

  assign p_o   = (xa == '0) && (ya == '0);
  assign q_o   = (xb == '0) && (yb == '0);
  assign u_one = (u == ONE);
  assign v_one = (v == ONE);

  always_comb begin
    chk = CASE_ADD;
    if (p_o && q_o)                chk = CASE_INF;
    else if (p_o)                  chk = CASE_Q;
    else if (q_o)                  chk = CASE_P;
    else if (xa == xb && sy == '0) chk = CASE_INF;
    else if (xa == xb && ya == yb)
`ifdef POINT_DOUBLE_EN
      chk = CASE_DBL;
`else
      chk = CASE_INF;
`endif
  end

  mod_mult #(.n(n)) u_mult (
    .clk    (clk),
    .reset  (reset),
    .a      (mul_a),
    .b      (mul_b),
    .p      (pr),
    .start  (mul_start),
    .product(mul_prod),
    .done   (mul_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      ph <= 1'b0;
    end else begin
      st <= st_nxt;
      ph <= ph_nxt;
    end
  end

  // ph = 0: issue a product (or iterate the inverse); ph = 1: wait for it.
  always_comb begin
    st_nxt    = st;
    ph_nxt    = ph;
    mul_start = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    case (st)
      IDLE:  st_nxt = LOAD;
      LOAD:  st_nxt = CHECK;
      CHECK: st_nxt = (chk == CASE_ADD || chk == CASE_DBL) ? LAMBDA : DONE;
      LAMBDA: begin
        mul_a = xa;
        mul_b = xa;
        if (!dbl) begin
          st_nxt = INV;
        end else if (!ph) begin
          mul_start = 1'b1;
          ph_nxt    = 1'b1;
        end else if (mul_done) begin
          ph_nxt = 1'b0;
          st_nxt = INV;
        end
      end
      INV: begin
        mul_a = num;
        mul_b = u_one ? s : t;
        if (!ph) begin
          if (u_one || v_one) begin
            mul_start = 1'b1;
            ph_nxt    = 1'b1;
          end
        end else if (mul_done) begin
          ph_nxt = 1'b0;
          st_nxt = X3;
        end
      end
      X3, Y3: begin
        mul_a = lam;
        mul_b = (st == X3) ? lam : msub(xa, xr, pr);
        if (!ph) begin
          mul_start = 1'b1;
          ph_nxt    = 1'b1;
        end else if (mul_done) begin
          ph_nxt = 1'b0;
          st_nxt = (st == X3) ? Y3 : DONE;
        end
      end
      DONE:    st_nxt = DONE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pr <= '0; xa <= '0; ya <= '0; xb <= '0; yb <= '0;
      num <= '0; lam <= '0; xr <= '0; sy <= '0;
      u <= '0; v <= '0; s <= '0; t <= '0;
      dbl <= 1'b0;
      x3 <= '0; y3 <= '0;
      result <= 1'b0; infinity <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          pr <= p; xa <= x1; ya <= y1; xb <= x2; yb <= y2;
        end
        // Addition operands by default; the doubling path overwrites num/u in LAMBDA.
        LOAD: begin
          num <= msub(yb, ya, pr);
          u   <= msub(xb, xa, pr);
          v   <= pr;
          s   <= ONE;
          t   <= '0;
          sy  <= madd(ya, yb, pr);
        end
        CHECK: begin
          case (chk)
            CASE_Q:   begin x3 <= xb; y3 <= yb; result <= 1'b1; end
            CASE_P:   begin x3 <= xa; y3 <= ya; result <= 1'b1; end
            CASE_INF: begin x3 <= '0; y3 <= '0; infinity <= 1'b1; end
            CASE_DBL: dbl <= 1'b1;
            default: ;
          endcase
        end
        LAMBDA: begin
          if (dbl && ph && mul_done) begin
            num <= madd(madd(madd(mul_prod, mul_prod, pr), mul_prod, pr), CURVE_A, pr);
            u   <= madd(ya, ya, pr);
          end
        end
        // Invariants s*den == u and t*den == v (mod p); each step halves u or v.
        INV: begin
          if (!ph) begin
            if (!u_one && !v_one) begin
              if (!u[0]) begin
                u <= u >> 1;
                s <= mhalf(s, pr);
              end else if (!v[0]) begin
                v <= v >> 1;
                t <= mhalf(t, pr);
              end else if (u >= v) begin
                u <= (u - v) >> 1;
                s <= mhalf(msub(s, t, pr), pr);
              end else begin
                v <= (v - u) >> 1;
                t <= mhalf(msub(t, s, pr), pr);
              end
            end
          end else if (mul_done) begin
            lam <= mul_prod;
          end
        end
        X3: if (ph && mul_done) xr <= msub(msub(mul_prod, xa, pr), xb, pr);
        Y3: begin
          if (ph && mul_done) begin
            x3     <= xr;
            y3     <= msub(mul_prod, ya, pr);
            result <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_point_addition.sv
// Directed bench for point_addition: small-prime vectors plus secp256k1 cases
// against a Fermat-inverse reference model. Honours POINT_DOUBLE_EN.
module tb_point_addition;

  localparam int W     = 256;
  localparam int LIMIT = 12 * W + 64 + 2;
  localparam logic [W-1:0] SP =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [W-1:0] GX =
    256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [W-1:0] GY =
    256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;

  typedef struct packed {
    logic         inf;
    logic [W-1:0] x;
    logic [W-1:0] y;
  } pt_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] p, x1, y1, x2, y2;
  logic [W-1:0] x3, y3;
  logic         result, infinity;
  int           n_checks = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  point_addition #(.n(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .p       (p),
    .x1      (x1),
    .y1      (y1),
    .x2      (x2),
    .y2      (y2),
    .x3      (x3),
    .y3      (y3),
    .result  (result),
    .infinity(infinity)
  );

  // Reference field arithmetic over the secp256k1 prime.
  function automatic logic [W-1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    r = ({1'b0, a} + {1'b0, b}) % {1'b0, SP};
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] fsub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    r = ({1'b0, a} + {1'b0, SP} - {1'b0, b}) % {1'b0, SP};
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] r;
    r = ({{W{1'b0}}, a} * {{W{1'b0}}, b}) % {{W{1'b0}}, SP};
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] finv(input logic [W-1:0] a);
    logic [W-1:0] r;
    logic [W-1:0] e;
    r = W'(1);
    e = SP - W'(2);
    for (int i = W - 1; i >= 0; i--) begin
      r = fmul(r, r);
      if (e[i]) r = fmul(r, a);
    end
    return r;
  endfunction

  function automatic pt_t padd(input pt_t a, input pt_t b);
    logic [W-1:0] lam;
    pt_t          r;
    r = '0;
    if (a.inf) return b;
    if (b.inf) return a;
    if (a.x == b.x) begin
      if (fadd(a.y, b.y) == '0) begin
        r.inf = 1'b1;
        return r;
      end
      lam = fmul(fmul(W'(3), fmul(a.x, a.x)), finv(fadd(a.y, a.y)));
    end else begin
      lam = fmul(fsub(b.y, a.y), finv(fsub(b.x, a.x)));
    end
    r.x = fsub(fsub(fmul(lam, lam), a.x), b.x);
    r.y = fsub(fmul(lam, fsub(a.x, r.x)), a.y);
    return r;
  endfunction

  function automatic pt_t smul(input int k, input pt_t g);
    pt_t r;
    r = g;
    for (int i = 1; i < k; i++) r = padd(r, g);
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] pp, input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input logic [W-1:0] a2, input logic [W-1:0] b2);
    @(negedge clk);
    reset = 1'b0;
    p = pp; x1 = a1; y1 = b1; x2 = a2; y2 = b2;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!(result || infinity) && cyc <= LIMIT) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_out(input string tag, input int cyc, input logic er, input logic ei,
                           input logic [W-1:0] ex, input logic [W-1:0] ey);
    check({tag, "_latency_ok"}, W'(cyc <= LIMIT), W'(1));
    check({tag, "_result"}, W'(result), W'(er));
    check({tag, "_infinity"}, W'(infinity), W'(ei));
    check({tag, "_x3"}, x3, ex);
    check({tag, "_y3"}, y3, ey);
  endtask

  task automatic run_case(input string tag, input logic [W-1:0] pp,
                          input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input logic [W-1:0] a2, input logic [W-1:0] b2,
                          input logic er, input logic ei,
                          input logic [W-1:0] ex, input logic [W-1:0] ey);
    int cyc;
    launch(pp, a1, b1, a2, b2);
    wait_done(cyc);
    check_out(tag, cyc, er, ei, ex, ey);
  endtask

  initial begin
    int  cyc;
    int  k1, k2;
    pt_t g, g2, pa, pb, e;

    p = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    repeat (3) @(negedge clk);
    check("reset_x3", x3, '0);
    check("reset_y3", y3, '0);
    check("reset_result", W'(result), W'(0));
    check("reset_infinity", W'(infinity), W'(0));

    // Addition; inputs are scrambled after sampling and must be ignored.
    launch(W'(17), W'(1), W'(5), W'(2), W'(7));
    repeat (3) @(negedge clk);
    x1 = W'(3); y1 = W'(3); x2 = W'(4); y2 = W'(9); p = W'(13);
    wait_done(cyc);
    check_out("add", cyc, 1'b1, 1'b0, W'(1), W'(12));
    repeat (5) @(negedge clk);
    check("add_hold_x3", x3, W'(1));
    check("add_hold_y3", y3, W'(12));
    check("add_hold_result", W'(result), W'(1));
    #2 reset = 1'b0;
    #1;
    check("async_clr_result", W'(result), W'(0));
    check("async_clr_y3", y3, '0);

`ifdef POINT_DOUBLE_EN
    run_case("double", W'(17), W'(2), W'(7), W'(2), W'(7), 1'b1, 1'b0, W'(12), W'(16));
`else
    run_case("double_off", W'(17), W'(2), W'(7), W'(2), W'(7), 1'b0, 1'b1, '0, '0);
`endif
    run_case("inverse", W'(17), W'(2), W'(7), W'(2), W'(10), 1'b0, 1'b1, '0, '0);
    run_case("ident_p", W'(17), W'(0), W'(0), W'(1), W'(5), 1'b1, 1'b0, W'(1), W'(5));
    run_case("ident_q", W'(17), W'(1), W'(5), W'(0), W'(0), 1'b1, 1'b0, W'(1), W'(5));

    // Abort mid-computation, then restart from scratch.
    launch(W'(17), W'(1), W'(5), W'(2), W'(7));
    repeat (20) @(negedge clk);
    check("midop_result", W'(result), W'(0));
    check("midop_x3", x3, '0);
    reset = 1'b0;
    #1;
    check("midop_rst_infinity", W'(infinity), W'(0));
    check("midop_rst_x3", x3, '0);
    run_case("rst_rerun", W'(17), W'(1), W'(5), W'(2), W'(7), 1'b1, 1'b0, W'(1), W'(12));

    // secp256k1 full width.
    g.inf = 1'b0; g.x = GX; g.y = GY;
    g2 = padd(g, g);
    e  = padd(g, g2);
    run_case("fw_g_2g", SP, g.x, g.y, g2.x, g2.y, 1'b1, 1'b0, e.x, e.y);
    for (int i = 0; i < 2; i++) begin
      k1 = int'($urandom_range(9, 2));
      k2 = k1 + int'($urandom_range(6, 1));
      pa = smul(k1, g);
      pb = smul(k2, g);
      e  = padd(pa, pb);
      run_case("fw_rand", SP, pa.x, pa.y, pb.x, pb.y, 1'b1, 1'b0, e.x, e.y);
    end
    run_case("fw_neg", SP, g2.x, g2.y, g2.x, SP - g2.y, 1'b0, 1'b1, '0, '0);
`ifdef POINT_DOUBLE_EN
    e = padd(g2, g2);
    run_case("fw_double", SP, g2.x, g2.y, g2.x, g2.y, 1'b1, 1'b0, e.x, e.y);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
